// File: rtl/ppm_symbol_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ppm_symbol_shifter
// Purpose  : Serialises DATA_W-bit words into SYM_W-bit PPM symbols, each held
//            for SYM_CYCLES clocks, behind a one-word valid/ready buffer.
// Revision : 1.0 - initial release
// ============================================================================
module ppm_symbol_shifter #(
  parameter int DATA_W     = 8,
  parameter int SYM_W      = 2,
  parameter int SYM_CYCLES = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SYM_W-1:0]  sym_out,
  output logic              sym_valid,
  output logic              sym_first,
  output logic              data_send_done,
  output logic              busy
);

  localparam int C_NSYM  = DATA_W / SYM_W;
  localparam int C_CYC_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam int C_SYM_W = (C_NSYM > 1) ? $clog2(C_NSYM) : 1;
  localparam logic [C_CYC_W-1:0] C_CYC_LAST = C_CYC_W'(SYM_CYCLES - 1);
  localparam logic [C_SYM_W-1:0] C_SYM_LAST = C_SYM_W'(C_NSYM - 1);

  generate
    if (((DATA_W % SYM_W) != 0) || (SYM_CYCLES < 1)) begin : g_bad_params
      $error("ppm_symbol_shifter: DATA_W must be a multiple of SYM_W and SYM_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [C_CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [C_SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic                done_q, done_d;

  logic                w_accept;
  logic                w_sym_end;
  logic                w_word_end;
  logic [SYM_W-1:0]    w_sym;
  logic [DATA_W-1:0]   w_sh_next;

  assign w_accept   = in_valid && !hold_full_q;
  assign w_sym_end  = (cyc_cnt_q == C_CYC_LAST);
  assign w_word_end = w_sym_end && (sym_cnt_q == C_SYM_LAST);
  assign w_sh_next  = MSB_FIRST ? (sh_q << SYM_W) : (sh_q >> SYM_W);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sym = sh_q[DATA_W-1 -: SYM_W];
    end else begin : g_lsb_first
      assign w_sym = sh_q[SYM_W-1:0];
    end
  endgenerate

  // Accept only fires with the buffer empty and drain only with it full, so
  // the two hold_full updates below can never collide.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cyc_cnt_d   = cyc_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    done_d      = 1'b0;

    if (w_accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          sh_d        = hold_q;
          hold_full_d = 1'b0;
          cyc_cnt_d   = '0;
          sym_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!w_sym_end) begin
          cyc_cnt_d = cyc_cnt_q + C_CYC_W'(1);
        end else if (!w_word_end) begin
          cyc_cnt_d = '0;
          sym_cnt_d = sym_cnt_q + C_SYM_W'(1);
          sh_d      = w_sh_next;
        end else begin
          done_d    = 1'b1;
          cyc_cnt_d = '0;
          sym_cnt_d = '0;
          if (hold_full_q) begin
            sh_d        = hold_q;
            hold_full_d = 1'b0;
          end else begin
            sh_d    = w_sh_next;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      cyc_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      cyc_cnt_q   <= cyc_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      done_q      <= done_d;
    end
  end

  assign in_ready       = !hold_full_q;
  assign sym_valid      = (state_q == ST_SHIFT);
  assign sym_out        = sym_valid ? w_sym : '0;
  assign sym_first      = sym_valid && (sym_cnt_q == '0);
  assign data_send_done = done_q;
  assign busy           = sym_valid || hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_ppm_symbol_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppm_symbol_shifter
// Purpose  : Directed and streaming checks of three shifter configurations
//            against a word/position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppm_symbol_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_v [3];
  logic [15:0] din  [3];
  bit          phase_rand;
  int          n_chk = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          dut_done_cnt = 0;

  int c_dw  [3] = '{8, 8, 16};
  int c_sw  [3] = '{2, 2, 4};
  int c_sc  [3] = '{4, 4, 1};
  int c_msb [3] = '{1, 0, 1};

  logic       d0_ir, d0_sv, d0_sf, d0_done, d0_busy;
  logic [1:0] d0_sym;
  logic       d1_ir, d1_sv, d1_sf, d1_done, d1_busy;
  logic [1:0] d1_sym;
  logic       d2_ir, d2_sv, d2_sf, d2_done, d2_busy;
  logic [3:0] d2_sym;

  logic [3:0] o_sym [3];
  logic       o_ir [3], o_sv [3], o_sf [3], o_done [3], o_busy [3];

  always #5 clk = ~clk;

  ppm_symbol_shifter u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(din[0][7:0]), .in_valid(in_v[0]),
    .in_ready(d0_ir), .sym_out(d0_sym), .sym_valid(d0_sv), .sym_first(d0_sf),
    .data_send_done(d0_done), .busy(d0_busy)
  );

  ppm_symbol_shifter #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .data_in(din[1][7:0]), .in_valid(in_v[1]),
    .in_ready(d1_ir), .sym_out(d1_sym), .sym_valid(d1_sv), .sym_first(d1_sf),
    .data_send_done(d1_done), .busy(d1_busy)
  );

  ppm_symbol_shifter #(.DATA_W(16), .SYM_W(4), .SYM_CYCLES(1)) u_wide (
    .clk(clk), .rst_n(rst_n), .data_in(din[2]), .in_valid(in_v[2]),
    .in_ready(d2_ir), .sym_out(d2_sym), .sym_valid(d2_sv), .sym_first(d2_sf),
    .data_send_done(d2_done), .busy(d2_busy)
  );

  assign o_sym[0] = {2'b00, d0_sym};
  assign o_sym[1] = {2'b00, d1_sym};
  assign o_sym[2] = d2_sym;
  assign o_ir[0] = d0_ir;     assign o_ir[1] = d1_ir;     assign o_ir[2] = d2_ir;
  assign o_sv[0] = d0_sv;     assign o_sv[1] = d1_sv;     assign o_sv[2] = d2_sv;
  assign o_sf[0] = d0_sf;     assign o_sf[1] = d1_sf;     assign o_sf[2] = d2_sf;
  assign o_done[0] = d0_done; assign o_done[1] = d1_done; assign o_done[2] = d2_done;
  assign o_busy[0] = d0_busy; assign o_busy[1] = d1_busy; assign o_busy[2] = d2_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word in flight plus a cycle position inside it,
  // and an optional buffered word.
  bit          m_act  [3];
  bit          m_hf   [3];
  bit          m_done [3];
  int          m_pos  [3];
  logic [15:0] m_cur  [3];
  logic [15:0] m_hold [3];
  int          tot_m;
  bit          acc_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] = 1'b0; m_hf[i] = 1'b0; m_done[i] = 1'b0;
        m_pos[i] = 0; m_cur[i] = '0; m_hold[i] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        tot_m = (c_dw[i] / c_sw[i]) * c_sc[i];
        acc_m = in_v[i] && !m_hf[i];
        m_done[i] = m_act[i] && (m_pos[i] == tot_m - 1);
        if (m_act[i] && (m_pos[i] < tot_m - 1)) begin
          m_pos[i]++;
        end else if (m_hf[i]) begin
          m_act[i] = 1'b1; m_cur[i] = m_hold[i]; m_pos[i] = 0; m_hf[i] = 1'b0;
        end else begin
          m_act[i] = 1'b0;
        end
        if (acc_m) begin
          m_hold[i] = din[i] & 16'((1 << c_dw[i]) - 1);
          m_hf[i]   = 1'b1;
          if (i == 0 && phase_rand) acc_cnt++;
        end
      end
    end
  end

  function automatic logic [3:0] exp_sym(input int i);
    int nsym = c_dw[i] / c_sw[i];
    int idx;
    int sh;
    if (!m_act[i]) return 4'h0;
    idx = m_pos[i] / c_sc[i];
    sh  = (c_msb[i] != 0) ? (nsym - 1 - idx) * c_sw[i] : idx * c_sw[i];
    return 4'((32'(m_cur[i]) >> sh) & ((1 << c_sw[i]) - 1));
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.sym_out", i),        o_sym[i],  exp_sym(i));
      chk($sformatf("u%0d.sym_valid", i),      o_sv[i],   m_act[i]);
      chk($sformatf("u%0d.sym_first", i),      o_sf[i],   m_act[i] && (m_pos[i] / c_sc[i] == 0));
      chk($sformatf("u%0d.data_send_done", i), o_done[i], m_done[i]);
      chk($sformatf("u%0d.busy", i),           o_busy[i], m_act[i] || m_hf[i]);
      chk($sformatf("u%0d.in_ready", i),       o_ir[i],   !m_hf[i]);
    end
    if (phase_rand && o_done[0]) dut_done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [1:0] t_msb [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [1:0] t_lsb [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
  logic [1:0] t_b2b [8] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00};

  initial begin
    rst_n = 1'b0;
    phase_rand = 1'b0;
    for (int i = 0; i < 3; i++) begin in_v[i] = 1'b0; din[i] = '0; end
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) begin
      chk("rst.sym_valid", o_sv[i], 1'b0);
      chk("rst.in_ready",  o_ir[i], 1'b1);
      chk("rst.busy",      o_busy[i], 1'b0);
      chk("rst.sym_out",   o_sym[i], 4'h0);
    end
    rst_n = 1'b1;
    repeat (2) cyc();

    // Single word 8'b01101100, MSB-first and LSB-first side by side
    din[0] = 16'h006C; din[1] = 16'h006C; in_v[0] = 1'b1; in_v[1] = 1'b1;
    cyc();
    in_v[0] = 1'b0; in_v[1] = 1'b0;
    chk("w1.in_ready_low", d0_ir, 1'b0);
    chk("w1.not_yet_valid", d0_sv, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      cyc();
      if (k <= 16) begin
        chk("w1.msb_sym", d0_sym, t_msb[(k - 1) / 4]);
        chk("w1.lsb_sym", d1_sym, t_lsb[(k - 1) / 4]);
        chk("w1.sym_first", d0_sf, k <= 4);
        chk("w1.done_low", d0_done, 1'b0);
      end
      if (k == 1) chk("w1.in_ready_back", d0_ir, 1'b1);
      if (k == 17) begin
        chk("w1.done_pulse", d0_done, 1'b1);
        chk("w1.lsb_done_pulse", d1_done, 1'b1);
        chk("w1.valid_fall", d0_sv, 1'b0);
      end
      if (k == 18) chk("w1.done_single", d0_done, 1'b0);
    end

    // Back-to-back A5 then 3C with in_valid held high
    din[0] = 16'h00A5; in_v[0] = 1'b1;
    cyc();
    din[0] = 16'h003C;
    chk("b2b.ready_low", d0_ir, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      cyc();
      if (k == 1) chk("b2b.ready_e1", d0_ir, 1'b1);
      if (k == 2) begin
        in_v[0] = 1'b0;
        chk("b2b.second_accepted", d0_ir, 1'b0);
      end
      if (k <= 32) begin
        chk("b2b.sym", d0_sym, t_b2b[(k - 1) / 4]);
        chk("b2b.no_gap", d0_sv, 1'b1);
      end
      if (k == 17) begin
        chk("b2b.done1", d0_done, 1'b1);
        chk("b2b.first2", d0_sf, 1'b1);
      end
      if (k == 33) begin
        chk("b2b.done2", d0_done, 1'b1);
        chk("b2b.valid_fall", d0_sv, 1'b0);
      end
    end

    // 16-bit word, 4-bit symbols, one clock per symbol
    din[2] = 16'h1234; in_v[2] = 1'b1;
    cyc();
    in_v[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k <= 4) chk("wide.sym", d2_sym, 4'(k));
      chk("wide.done", d2_done, k == 5);
    end

    // Reset mid-word with a second word buffered
    din[0] = 16'h006C; in_v[0] = 1'b1;
    cyc();
    din[0] = 16'h0099;
    cyc();
    cyc();
    in_v[0] = 1'b0;
    repeat (7) cyc();
    chk("rstmid.busy_before", d0_busy, 1'b1);
    chk("rstmid.ready_before", d0_ir, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.sym_valid", d0_sv, 1'b0);
    chk("rstmid.sym_out", d0_sym, 2'b00);
    chk("rstmid.in_ready", d0_ir, 1'b1);
    chk("rstmid.busy", d0_busy, 1'b0);
    repeat (2) begin
      cyc();
      chk("rstmid.no_done", d0_done, 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("rstmid.no_done_after", d0_done, 1'b0);
    din[0] = 16'h00C3; in_v[0] = 1'b1;
    cyc();
    in_v[0] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 1)  chk("rstmid.fresh_sym0", d0_sym, 2'b11);
      if (k == 13) chk("rstmid.fresh_sym3", d0_sym, 2'b11);
      if (k == 17) chk("rstmid.fresh_done", d0_done, 1'b1);
    end
    repeat (2) cyc();

    // Random in_valid streaming, 1000 words on the default configuration
    phase_rand = 1'b1;
    for (int c = 0; c < 40000 && acc_cnt < 1000; c++) begin
      in_v[0] = 1'($urandom_range(0, 1));
      din[0]  = 16'($urandom);
      cyc();
    end
    in_v[0] = 1'b0;
    chk("rand.words_accepted", acc_cnt, 1000);
    repeat (40) cyc();
    phase_rand = 1'b0;
    chk("rand.done_per_word", dut_done_cnt, acc_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ppm_symbol_shifter.md
# ppm_symbol_shifter

Parametrised PPM transmitter front end that serialises DATA_W-bit words into SYM_W-bit PPM symbols. Each symbol is held for SYM_CYCLES clocks. A one-word holding buffer with valid/ready handshake lets words stream back-to-back with no idle slot between them. The block sits between the byte source (UART/FIFO side) and the PPM slot modulator. It succeeds the fixed 8-bit/2-bit strobe-driven shifter.

## Interface
- DATA_W, default 8: bits per input word; must be a multiple of SYM_W (elaboration error otherwise).
- SYM_W, default 2: bits per PPM symbol (1 = 2-PPM, 2 = 4-PPM, 3 = 8-PPM, 4 = 16-PPM).
- SYM_CYCLES, default 4: clocks each symbol is presented; ≥1.
- MSB_FIRST, default 1: 1 = most significant symbol first, 0 = least significant first.
- Derived: NSYM = DATA_W/SYM_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  word to transmit.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  holding buffer empty; a word transfers on an edge where in_valid && in_ready.
- sym_out  out  SYM_W  current symbol; 0 when idle.
- sym_valid  out  1  sym_out carries a live symbol.
- sym_first  out  1  high while the first symbol of a word is presented.
- data_send_done  out  1  one-cycle pulse after the final cycle of a word's last symbol.
- busy  out  1  shifter active or holding buffer full.

## Operation
- Storage:
  - holding register hold_q plus flag hold_full.
  - shift register sh_q.
  - cycle counter cyc_cnt, range 0..SYM_CYCLES-1.
  - symbol counter sym_cnt, range 0..NSYM-1.
- in_ready = !hold_full (combinational). Accept sets hold_full and captures data_in into hold_q.
- Accept and drain never coincide: drain only happens while hold_full = 1, when in_ready = 0.
- States are IDLE and SHIFT.
- IDLE:
  - sym_valid = 0, sym_out = 0.
  - If hold_full: load sh_q from hold_q, clear hold_full, zero both counters, go to SHIFT.
- SHIFT:
  - sym_out = top SYM_W bits of sh_q when MSB_FIRST, else bottom SYM_W bits.
  - cyc_cnt increments each clock.
  - When cyc_cnt = SYM_CYCLES-1: cyc_cnt wraps to 0, sym_cnt increments, sh_q shifts by SYM_W (left if MSB_FIRST, else right, zero fill).
- End of word (cyc_cnt = SYM_CYCLES-1 and sym_cnt = NSYM-1):
  - Pulse data_send_done in the following cycle.
  - If hold_full on that edge: reload from hold_q, clear hold_full, zero counters, stay in SHIFT. No gap; sym_first reasserts.
  - Else: go to IDLE.
- sym_first = SHIFT && sym_cnt = 0.
- busy = (state = SHIFT) || hold_full.
- Outputs are registered state or pure decodes of it; no combinational path from data_in/in_valid to the symbol outputs.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - state IDLE, hold_full 0, counters 0, sh_q 0, hold_q 0.
  - sym_out 0, sym_valid 0, sym_first 0, data_send_done 0, busy 0, in_ready 1.
- Latency: word accepted at edge E. First symbol is valid from edge E+1 (hold → shifter).
- Word duration: sym_valid high for NSYM·SYM_CYCLES consecutive cycles. data_send_done is high exactly one cycle, starting at edge E+1+NSYM·SYM_CYCLES.
- in_ready: low for the single cycle after an accept when idle. Otherwise low from accept until the reload edge.
- Sustained streaming: throughput is one word per NSYM·SYM_CYCLES clocks.
- Back-to-back: data_send_done for word k coincides with the first symbol cycle of word k+1.
- SYM_CYCLES = 1: a new symbol every clock; counters still behave as above.
- Reset mid-word: output stops immediately; buffered word discarded; no data_send_done.

## Test plan
- Defaults, data_in = 8'b01101100, one-cycle in_valid at edge E:
  - in_ready low one cycle.
  - sym_out = 01,10,11,00, each for 4 cycles, starting E+1.
  - sym_first high cycles 1–4 only.
  - data_send_done single pulse at E+17; sym_valid falls at E+17.
- MSB_FIRST = 0, same word: sym_out = 00,11,10,01.
- Back-to-back 8'hA5 then 8'h3C, in_valid held high:
  - Second word accepted at E+2; 8 contiguous symbols 10,10,01,01,00,11,11,00.
  - No sym_valid gap; first done pulse overlaps the second sym_first.
  - Second done at E+33.
- DATA_W = 16, SYM_W = 4, SYM_CYCLES = 1, data 16'h1234:
  - sym_out 1,2,3,4 on consecutive cycles.
  - Done at E+5.
- rst_n asserted mid-word (after symbol 2, with hold_full set):
  - All outputs return to reset values asynchronously; in_ready = 1.
  - No done pulse.
  - After release, a fresh word is transmitted correctly.
- in_valid toggling randomly against a reference model for 1000 words: every accepted word is emitted exactly once, in order, with one done pulse per word.
